rx_bit_sampler: RTL and testbench
=================================

// Module: rx_bit_sampler
// PURPOSE
//  - UART RX front end, directly upstream of stop/parity/start checkers and deserializer.
//  - Oversamples RX_IN at CLK = prescale x baud.
//  - Runs the edge and bit counters.
//  - Majority-votes 3 mid-bit samples into sampled_bit, with a 1-cycle sample_valid strobe that checkers use as their enable.
// PARAMETERS
//  PRESCALE_WIDTH  6   width of prescale input and edge_cnt (max prescale 32)
//  BIT_CNT_WIDTH   4   width of bit_cnt
//  FRAME_BITS      11  bits per frame (start + 8 data + parity + stop); bit_cnt wraps here
// PORTS
//  CLK           in   1               single clock, all logic on rising edge
//  RST           in   1               reset, synchronous, active-high
//  RX_IN         in   1               serial line, idle high
//  enable        in   1               from RX FSM; high while a frame is being received
//  prescale      in   PRESCALE_WIDTH  oversampling ratio: 8, 16 or 32
//  sampled_bit   out  1               majority-voted bit value
//  sample_valid  out  1               1-cycle pulse; sampled_bit updated this cycle
//  edge_cnt      out  PRESCALE_WIDTH  oversample index within the current bit
//  bit_cnt       out  BIT_CNT_WIDTH   bit index within the frame
//  bit_done      out  1               1-cycle pulse on the last edge of each bit
//  frame_done    out  1               1-cycle pulse on the last edge of bit FRAME_BITS-1
// BEHAVIOUR
//  - Reset (RST=1 at a CLK edge): all outputs 0, except sampled_bit=1 (idle level).
//    - Sample regs set to 1; prescale latch set to 8.
//    - Reset mid-frame aborts immediately; no strobe is emitted that cycle.
//  - enable low:
//    - edge_cnt=0, bit_cnt=0; all pulses 0; sampled_bit holds.
//    - prescale is latched into P every cycle while enable is low, so it is frozen for the whole frame.
//  - P rules: P = latched prescale with LSB forced 0. Values <8 are treated as 8. H = P/2.
//  - enable high: edge_cnt increments every CLK.
//    - At edge_cnt==P-1: edge_cnt wraps to 0 and bit_done=1 in the same cycle.
//    - On that wrap, bit_cnt increments; at bit_cnt==FRAME_BITS-1 it wraps to 0 instead and frame_done=1.
//  - Sampling:
//    - RX_IN (post-sync, see CONFIGURATION) is captured into s0/s1/s2 when edge_cnt==H-1, H and H+1.
//    - When edge_cnt==H+2: sampled_bit <= majority(s0,s1,s2), and sample_valid=1 for that one cycle.
//    - Latency from the centre sample (edge_cnt==H) to the strobe: 2 CLK.
//    - For P>=8, H+2 <= P-1, so the strobe never straddles a bit boundary. It may coincide with bit_done only when P=8 (edge 6 vs 7: it does not).
//  - enable falls in the same cycle that the vote would occur: no strobe; counters clear.
//  - enable rises: counting starts from edge_cnt=0 on the next edge. The RX FSM aligns enable to the start-bit falling edge.
//  - Outputs are registered; no combinational path from inputs to outputs.
// CONFIGURATION
//  - SAMPLER_SYNC_EN defined:
//    - RX_IN passes a 2-flop synchronizer (reset to 1) before sampling.
//    - Sample timing is unchanged relative to edge_cnt. Line-to-sample delay grows by 2 CLK, which the FSM start-detect absorbs.
//  - Undefined: RX_IN is sampled directly, for when the top level already synchronizes it.
// STRUCTURE
//  - Package rx_pkg:
//    - FRAME_BITS_DEF, PRESCALE_MIN=8, IDLE_LEVEL=1'b1.
//    - function maj3(a,b,c).
//    - Shared with the deserializer and the checkers.
//  - Sub-module rx_edge_bit_counter:
//    - Holds the prescale latch, edge_cnt, bit_cnt, bit_done and frame_done.
//    - Reused by the deserializer's bit-index logic.
//  - The top holds the synchronizer, the sample regs and the vote.
// TESTING
//  - Reset: RST=1 for 2 CLK mid-frame.
//    -> sampled_bit=1 and all counters/pulses 0 on the next edge.
//    -> No sample_valid for 8 CLK after release with enable=0.
//  - Clean frame, prescale=8, byte 0xA5, even parity, stop=1:
//    -> 11 sample_valid pulses, each at edge_cnt==6.
//    -> Bit values 0,1,0,1,0,0,1,0,1,0,1 (LSB first).
//    -> frame_done exactly once.
//  - Glitch rejection, prescale=16:
//    - A single-cycle 0 glitch at edge_cnt==8 of a stop bit -> sampled_bit=1.
//    - A 2-cycle 0 at edge_cnt 7..8 -> sampled_bit=0.
//  - prescale=32, byte 0x3C -> strobes at edge_cnt==18 every 32 CLK; correct bits recovered.
//    - Changing prescale to 8 mid-frame has no effect until enable drops.
//  - Abort: enable drops at edge_cnt==H+2 of bit 4.
//    -> No strobe that cycle; edge_cnt=bit_cnt=0 on the next edge.
//  - prescale=5 -> behaves exactly as 8: strobe at edge 6, bit_done at edge 7.
//  - Repeat the clean-frame test with SAMPLER_SYNC_EN defined; RX_IN is shifted 2 CLK earlier to keep alignment.

Source files
------------

// File: rtl/rx_pkg.sv
// -----------------------------------------------------------------------------
// rx_pkg
// Constants and helpers shared across the UART RX path. The bit sampler,
// the deserializer and the stop/parity/start checkers all use this package.
//   FRAME_BITS_DEF : bits per frame (start + 8 data + parity + stop)
//   PRESCALE_MIN   : smallest oversampling ratio; smaller requests are raised to it
//   IDLE_LEVEL     : level of the serial line when it is idle
//   maj3()         : 2-of-3 majority vote
// -----------------------------------------------------------------------------
package rx_pkg;

  localparam int   FRAME_BITS_DEF = 11;
  localparam int   PRESCALE_MIN   = 8;
  localparam logic IDLE_LEVEL     = 1'b1;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/rx_bit_sampler_if.sv
// -----------------------------------------------------------------------------
// rx_bit_sampler_if
// Groups the sampler's line, control and status signals into one bundle.
//   master : the RX FSM side; it drives RX_IN/enable/prescale and reads status
//   slave  : the sampler side; it reads the controls and drives status
// Signals:
//   RX_IN        serial line, idle high
//   enable       high while a frame is being received
//   prescale     requested oversampling ratio (8, 16 or 32)
//   sampled_bit  majority-voted bit value
//   sample_valid one-cycle strobe; sampled_bit was updated on this edge
//   edge_cnt     oversample index within the current bit
//   bit_cnt      bit index within the frame
//   bit_done     one-cycle pulse on the last edge of each bit
//   frame_done   one-cycle pulse on the last edge of the last bit
// -----------------------------------------------------------------------------
interface rx_bit_sampler_if #(
  parameter int PRESCALE_WIDTH = 6,
  parameter int BIT_CNT_WIDTH  = 4
);

  logic                      RX_IN;
  logic                      enable;
  logic [PRESCALE_WIDTH-1:0] prescale;
  logic                      sampled_bit;
  logic                      sample_valid;
  logic [PRESCALE_WIDTH-1:0] edge_cnt;
  logic [BIT_CNT_WIDTH-1:0]  bit_cnt;
  logic                      bit_done;
  logic                      frame_done;

  modport master (
    output RX_IN, enable, prescale,
    input  sampled_bit, sample_valid, edge_cnt, bit_cnt, bit_done, frame_done
  );

  modport slave (
    input  RX_IN, enable, prescale,
    output sampled_bit, sample_valid, edge_cnt, bit_cnt, bit_done, frame_done
  );

endinterface

// File: rtl/rx_edge_bit_counter.sv
// -----------------------------------------------------------------------------
// rx_edge_bit_counter
// Oversample (edge) and bit counters for the UART RX path. The deserializer
// uses the same block for its bit-index logic.
// Ports:
//   CLK, RST    clock, synchronous active-high reset
//   enable      counting enable; while low, counters clear and prescale is latched
//   prescale    requested oversampling ratio
//   edge_cnt    oversample index within the current bit (registered)
//   bit_cnt     bit index within the frame (registered)
//   bit_done    pulse set on the edge where edge_cnt wraps
//   frame_done  pulse set on the wrap of the last bit in the frame
//   p_eff       effective oversampling ratio in use for this frame
// -----------------------------------------------------------------------------
module rx_edge_bit_counter
  import rx_pkg::*;
#(
  parameter int PRESCALE_WIDTH = 6,
  parameter int BIT_CNT_WIDTH  = 4,
  parameter int FRAME_BITS     = FRAME_BITS_DEF
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      enable,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic [PRESCALE_WIDTH-1:0] edge_cnt,
  output logic [BIT_CNT_WIDTH-1:0]  bit_cnt,
  output logic                      bit_done,
  output logic                      frame_done,
  output logic [PRESCALE_WIDTH-1:0] p_eff
);

  localparam int PW = PRESCALE_WIDTH;
  localparam int BW = BIT_CNT_WIDTH;

  logic [PW-1:0] p_q, p_d;
  logic [PW-1:0] edge_cnt_q, edge_cnt_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic          bit_done_q, bit_done_d;
  logic          frame_done_q, frame_done_d;

  always_comb begin
    p_d          = p_q;
    edge_cnt_d   = edge_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    bit_done_d   = 1'b0;
    frame_done_d = 1'b0;
    if (!enable) begin
      // The ratio is only taken while idle so it stays frozen for a whole frame.
      // Odd ratios are rounded down to even so the bit centre is well defined.
      if (prescale < PW'(PRESCALE_MIN)) begin
        p_d = PW'(PRESCALE_MIN);
      end else begin
        p_d = {prescale[PW-1:1], 1'b0};
      end
      edge_cnt_d = '0;
      bit_cnt_d  = '0;
    end else if (edge_cnt_q == p_q - PW'(1)) begin
      edge_cnt_d = '0;
      bit_done_d = 1'b1;
      if (bit_cnt_q == BW'(FRAME_BITS - 1)) begin
        bit_cnt_d    = '0;
        frame_done_d = 1'b1;
      end else begin
        bit_cnt_d = bit_cnt_q + BW'(1);
      end
    end else begin
      edge_cnt_d = edge_cnt_q + PW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      p_q          <= PW'(PRESCALE_MIN);
      edge_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      bit_done_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      p_q          <= p_d;
      edge_cnt_q   <= edge_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      bit_done_q   <= bit_done_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign edge_cnt   = edge_cnt_q;
  assign bit_cnt    = bit_cnt_q;
  assign bit_done   = bit_done_q;
  assign frame_done = frame_done_q;
  assign p_eff      = p_q;

endmodule

// File: rtl/rx_bit_sampler.sv
// -----------------------------------------------------------------------------
// rx_bit_sampler
// UART RX front end: oversamples the serial line, runs the edge/bit counters
// and majority-votes three mid-bit samples into sampled_bit with a one-cycle
// sample_valid strobe.
// Ports:
//   CLK, RST  clock, synchronous active-high reset
//   bus       rx_bit_sampler_if.slave (RX_IN, enable, prescale in;
//             sampled_bit, sample_valid, edge_cnt, bit_cnt, bit_done,
//             frame_done out)
// Build option:
//   SAMPLER_SYNC_EN  when defined, RX_IN goes through a 2-flop synchronizer
//                    before sampling (line-to-sample delay grows by 2 CLK).
//                    When undefined, RX_IN is assumed already synchronous.
// Timing: with H = P/2, the line is captured on the edges where edge_cnt is
// H-1, H and H+1; the vote and strobe happen on the edge where edge_cnt is H+2.
// -----------------------------------------------------------------------------
module rx_bit_sampler
  import rx_pkg::*;
#(
  parameter int PRESCALE_WIDTH = 6,
  parameter int BIT_CNT_WIDTH  = 4,
  parameter int FRAME_BITS     = FRAME_BITS_DEF
) (
  input logic                CLK,
  input logic                RST,
  rx_bit_sampler_if.slave    bus
);

  localparam int PW = PRESCALE_WIDTH;

  logic [PW-1:0]            edge_cnt;
  logic [BIT_CNT_WIDTH-1:0] bit_cnt;
  logic                     bit_done;
  logic                     frame_done;
  logic [PW-1:0]            p_eff;
  logic [PW-1:0]            half;
  logic                     rx_samp;

  rx_edge_bit_counter #(
    .PRESCALE_WIDTH (PRESCALE_WIDTH),
    .BIT_CNT_WIDTH  (BIT_CNT_WIDTH),
    .FRAME_BITS     (FRAME_BITS)
  ) u_counter (
    .CLK        (CLK),
    .RST        (RST),
    .enable     (bus.enable),
    .prescale   (bus.prescale),
    .edge_cnt   (edge_cnt),
    .bit_cnt    (bit_cnt),
    .bit_done   (bit_done),
    .frame_done (frame_done),
    .p_eff      (p_eff)
  );

  assign half = p_eff >> 1;

`ifdef SAMPLER_SYNC_EN
  logic [1:0] sync_q, sync_d;

  assign sync_d  = {sync_q[0], bus.RX_IN};
  assign rx_samp = sync_q[1];

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_q <= {2{IDLE_LEVEL}};
    end else begin
      sync_q <= sync_d;
    end
  end
`else
  assign rx_samp = bus.RX_IN;
`endif

  // Sample register gi captures the line on the edge where edge_cnt == H-1+gi.
  logic [2:0] s_q, s_d;

  for (genvar gi = 0; gi < 3; gi++) begin : g_sample
    assign s_d[gi] = (bus.enable && (edge_cnt == half + PW'(gi) - PW'(1)))
                     ? rx_samp : s_q[gi];
  end

  logic sampled_bit_q, sampled_bit_d;
  logic sample_valid_q, sample_valid_d;

  // All three samples are already registered by edge H+2, so the vote needs
  // no live line input and the strobe lands two edges after the centre sample.
  always_comb begin
    sampled_bit_d  = sampled_bit_q;
    sample_valid_d = 1'b0;
    if (bus.enable && (edge_cnt == half + PW'(2))) begin
      sampled_bit_d  = maj3(s_q[0], s_q[1], s_q[2]);
      sample_valid_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      s_q            <= {3{IDLE_LEVEL}};
      sampled_bit_q  <= IDLE_LEVEL;
      sample_valid_q <= 1'b0;
    end else begin
      s_q            <= s_d;
      sampled_bit_q  <= sampled_bit_d;
      sample_valid_q <= sample_valid_d;
    end
  end

  assign bus.sampled_bit  = sampled_bit_q;
  assign bus.sample_valid = sample_valid_q;
  assign bus.edge_cnt     = edge_cnt;
  assign bus.bit_cnt      = bit_cnt;
  assign bus.bit_done     = bit_done;
  assign bus.frame_done   = frame_done;

endmodule

// File: tb/tb_rx_bit_sampler.sv
// -----------------------------------------------------------------------------
// tb_rx_bit_sampler
// Directed and randomized frames against a frame-level reference model: the
// k-th enabled edge of a frame lies in bit k/P at oversample k%P, and a bit's
// value is the 2-of-3 majority of the line seen at oversamples H-1..H+1.
// Build with SAMPLER_SYNC_EN to match a synchronizer-enabled DUT; the line is
// then driven 2 CLK earlier.
// -----------------------------------------------------------------------------
module tb_rx_bit_sampler;

  localparam int PW = 6;
  localparam int BW = 4;
  localparam int FB = 11;
`ifdef SAMPLER_SYNC_EN
  localparam int DLY = 2;
`else
  localparam int DLY = 0;
`endif

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  rx_bit_sampler_if #(.PRESCALE_WIDTH(PW), .BIT_CNT_WIDTH(BW)) bus ();

  rx_bit_sampler #(
    .PRESCALE_WIDTH (PW),
    .BIT_CNT_WIDTH  (BW),
    .FRAME_BITS     (FB)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  int   checks = 0;
  int   errors = 0;
  int   exp_sb;
  logic line_at [0:1023];
  int   frame_bits [0:10];
  int   got_bits [$];
  int   n_frame_done;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int eff_p(input int p);
    return (p < 8) ? 8 : (p & ~1);
  endfunction

  // Start 0, data LSB first, even parity, stop 1; line placed DLY edges early.
  task automatic build_frame(input logic [7:0] data, input int p);
    int idx;
    frame_bits[0] = 0;
    for (int i = 0; i < 8; i++) frame_bits[1+i] = int'(data[i]);
    frame_bits[9]  = int'(^data);
    frame_bits[10] = 1;
    for (int k = 0; k < 1024; k++) begin
      idx = (k + DLY) / p;
      line_at[k] = (idx <= 10) ? frame_bits[idx][0] : 1'b1;
    end
  endtask

  task automatic idle(input int n, input int presc);
    for (int i = 0; i < n; i++) begin
      bus.enable   = 1'b0;
      bus.RX_IN    = 1'b1;
      bus.prescale = PW'(presc);
      @(posedge clk); #1;
      chk("idle_edge_cnt", int'(bus.edge_cnt), 0);
      chk("idle_bit_cnt", int'(bus.bit_cnt), 0);
      chk("idle_bit_done", int'(bus.bit_done), 0);
      chk("idle_frame_done", int'(bus.frame_done), 0);
      chk("idle_sample_valid", int'(bus.sample_valid), 0);
      chk("idle_sampled_bit", int'(bus.sampled_bit), exp_sb);
    end
  endtask

  task automatic run_enabled(input int n_edges, input int p, input int chg_at);
    int h, e, b, sum;
    h = p / 2;
    got_bits.delete();
    n_frame_done = 0;
    for (int k = 0; k < n_edges; k++) begin
      bus.enable = 1'b1;
      bus.RX_IN  = line_at[k];
      if (k == chg_at) bus.prescale = PW'(8);
      @(posedge clk); #1;
      e = k % p;
      b = (k / p) % FB;
      chk("edge_cnt", int'(bus.edge_cnt), (k + 1) % p);
      chk("bit_cnt", int'(bus.bit_cnt), ((k + 1) / p) % FB);
      chk("bit_done", int'(bus.bit_done), (e == p - 1) ? 1 : 0);
      chk("frame_done", int'(bus.frame_done), (e == p - 1 && b == FB - 1) ? 1 : 0);
      chk("sample_valid", int'(bus.sample_valid), (e == h + 2) ? 1 : 0);
      if (e == h + 2) begin
        sum = int'(line_at[k-3-DLY]) + int'(line_at[k-2-DLY]) + int'(line_at[k-1-DLY]);
        exp_sb = (sum >= 2) ? 1 : 0;
      end
      chk("sampled_bit", int'(bus.sampled_bit), exp_sb);
      if (bus.sample_valid) got_bits.push_back(int'(bus.sampled_bit));
      if (bus.frame_done) n_frame_done++;
    end
    $display("frame P=%0d edges=%0d strobes=%0d frame_done=%0d", p, n_edges,
             got_bits.size(), n_frame_done);
  endtask

  task automatic chk_frame_bits(input string tag);
    chk({tag, "_strobes"}, got_bits.size(), 11);
    chk({tag, "_frame_done"}, n_frame_done, 1);
    for (int i = 0; i < 11; i++) begin
      if (i < got_bits.size()) chk({tag, "_bit"}, got_bits[i], frame_bits[i]);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_sampled_bit"}, int'(bus.sampled_bit), 1);
    chk({tag, "_sample_valid"}, int'(bus.sample_valid), 0);
    chk({tag, "_edge_cnt"}, int'(bus.edge_cnt), 0);
    chk({tag, "_bit_cnt"}, int'(bus.bit_cnt), 0);
    chk({tag, "_bit_done"}, int'(bus.bit_done), 0);
    chk({tag, "_frame_done"}, int'(bus.frame_done), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int presc, p;
    int exp_a5 [0:10];
    int plist [0:4];
    logic [7:0] data;

    rst = 1'b1;
    bus.enable = 1'b0;
    bus.RX_IN = 1'b1;
    bus.prescale = PW'(8);
    exp_sb = 1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_state("por");
    rst = 1'b0;

    // Clean frame 0xA5 at prescale 8, against a literal bit list.
    exp_a5 = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
    idle(4, 8);
    build_frame(8'hA5, 8);
    run_enabled(88, 8, -1);
    chk_frame_bits("a5");
    for (int i = 0; i < 11; i++) begin
      if (i < got_bits.size()) chk("a5_literal_bit", got_bits[i], exp_a5[i]);
    end

    // Glitch rejection at prescale 16 in the stop bit.
    idle(3, 16);
    build_frame(8'h96, 16);
    line_at[10*16+8-DLY] = 1'b0;
    run_enabled(176, 16, -1);
    chk("glitch1_strobes", got_bits.size(), 11);
    if (got_bits.size() == 11) chk("glitch1_stop", got_bits[10], 1);

    idle(3, 16);
    build_frame(8'h96, 16);
    line_at[10*16+7-DLY] = 1'b0;
    line_at[10*16+8-DLY] = 1'b0;
    run_enabled(176, 16, -1);
    chk("glitch2_strobes", got_bits.size(), 11);
    if (got_bits.size() == 11) chk("glitch2_stop", got_bits[10], 0);

    // Prescale 32, byte 0x3C, prescale request changed to 8 mid-frame.
    idle(3, 32);
    build_frame(8'h3C, 32);
    run_enabled(352, 32, 100);
    chk_frame_bits("p32");

    // Abort: enable low on the edge where bit 4 would vote.
    idle(3, 8);
    build_frame(8'h55, 8);
    run_enabled(4*8+6, 8, -1);
    idle(1, 8);
    chk("abort_strobes", got_bits.size(), 4);

    // Prescale 5 behaves as 8.
    idle(3, 5);
    build_frame(8'h5A, 8);
    run_enabled(88, 8, -1);
    chk_frame_bits("p5");

    // Randomized frames with line noise; the model tracks every edge.
    plist = '{8, 16, 32, 9, 3};
    for (int r = 0; r < 6; r++) begin
      presc = (r < 5) ? plist[r] : int'($urandom_range(0, 40));
      p = eff_p(presc);
      data = 8'($urandom_range(0, 255));
      idle(2, presc);
      build_frame(data, p);
      for (int k = 0; k < 11*p; k++) begin
        if ($urandom_range(0, 9) == 0) line_at[k] = ~line_at[k];
      end
      run_enabled(11*p, p, -1);
      chk("rand_strobes", got_bits.size(), 11);
      chk("rand_frame_done", n_frame_done, 1);
    end

    // Reset held for 2 CLK mid-frame, then 8 idle cycles with no strobe.
    idle(3, 8);
    build_frame(8'h00, 8);
    run_enabled(21, 8, -1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_reset_state("rst1");
    @(posedge clk); #1;
    chk_reset_state("rst2");
    rst = 1'b0;
    exp_sb = 1;
    idle(8, 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
